// File: rtl/vx_fpu_req_sched_pkg.sv
// Shared types and sizing helpers for the FPU request scheduler.
package vx_fpu_req_sched_pkg;

   localparam int DEF_NUM_REQS   = 4;
   localparam int DEF_DATAW      = 128;
   localparam int DEF_QUEUE_SIZE = 8;

   typedef enum logic [0:0] {
      LOCK_UNLOCKED = 1'b0,
      LOCK_LOCKED   = 1'b1
   } lock_state_e;

   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   function automatic int cnt_width(input int q);
      return $clog2(q + 1);
   endfunction

endpackage

// File: rtl/vx_fpu_req_sched_if.sv
// Requester, FPU issue and FPU retire signals of the scheduler, bundled.
interface vx_fpu_req_sched_if #(
   parameter int NUM_REQS   = 4,
   parameter int DATAW      = 128,
   parameter int QUEUE_SIZE = 8
);
   import vx_fpu_req_sched_pkg::*;

   localparam int IDXW = idx_width(NUM_REQS);
   localparam int CNTW = cnt_width(QUEUE_SIZE);

   logic [NUM_REQS-1:0]            req_valid;
   logic [NUM_REQS-1:0][DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]            req_sop;
   logic [NUM_REQS-1:0]            req_eop;
   logic [NUM_REQS-1:0]            req_ready;

   logic                           out_valid;
   logic [DATAW-1:0]               out_data;
   logic [IDXW-1:0]                out_idx;
   logic                           out_eop;
   logic                           out_ready;

   logic                           rsp_done;
   logic [IDXW-1:0]                rsp_idx;

   logic [CNTW-1:0]                inflight;
   logic [NUM_REQS-1:0]            req_idle;

   modport master (
      output req_valid, req_data, req_sop, req_eop, out_ready, rsp_done, rsp_idx,
      input  req_ready, out_valid, out_data, out_idx, out_eop, inflight, req_idle
   );

   modport slave (
      input  req_valid, req_data, req_sop, req_eop, out_ready, rsp_done, rsp_idx,
      output req_ready, out_valid, out_data, out_idx, out_eop, inflight, req_idle
   );

endinterface

// File: rtl/vx_fpu_req_sched_arb.sv
// Round-robin winner select with a lock input that pins the grant to one owner.
module vx_fpu_req_sched_arb
   import vx_fpu_req_sched_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int IDXW     = idx_width(NUM_REQS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQS-1:0] i_valid,
   input  logic                i_lock,
   input  logic [IDXW-1:0]     i_owner,
   input  logic                i_advance,
   output logic                o_valid,
   output logic [IDXW-1:0]     o_winner
);

   logic [IDXW-1:0] r_ptr;
   logic            w_valid;
   logic [IDXW-1:0] w_winner;

   function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQS) begin
         s = s - NUM_REQS;
      end else begin
         s = s;
      end
      return s[IDXW-1:0];
   endfunction

   // Winner select: the owner while locked, else first valid requester at or after r_ptr
   always_comb begin
      w_valid  = 1'b0;
      w_winner = {IDXW{1'b0}};
      if (i_lock) begin
         w_valid  = i_valid[i_owner];
         w_winner = i_owner;
      end else begin
         // Scan downwards so the nearest requester to r_ptr is assigned last
         for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (i_valid[wrap_idx(r_ptr, k)]) begin
               w_valid  = 1'b1;
               w_winner = wrap_idx(r_ptr, k);
            end else begin
               w_valid  = w_valid;
            end
         end
      end
   end

   // Priority pointer moves past the winner only when a packet stream completes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= {IDXW{1'b0}};
      end else if (i_advance) begin
         r_ptr <= wrap_idx(w_winner, 1);
      end
   end

   assign o_valid  = w_valid;
   assign o_winner = w_winner;

endmodule

// File: rtl/vx_fpu_req_sched_chk.sv
// Simulation-only protocol checks on the scheduler's retire and issue sides.
module vx_fpu_req_sched_chk (
   input logic clk,
   input logic reset,
   input logic i_rsp_done,
   input logic i_rsp_zero,
   input logic i_fire,
   input logic i_sop,
   input logic i_unlocked
);

   // A retire for a requester with nothing in flight is illegal
   a_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
      !(i_rsp_done && i_rsp_zero));

   // A new packet stream must begin with its start-of-packet marker
   a_sop_on_start: assert property (@(posedge clk) disable iff (reset)
      (i_fire && i_unlocked) |-> i_sop);

endmodule

// File: rtl/vx_fpu_req_sched.sv
// Shares one FPU issue port among NUM_REQS requesters, with packet locking,
// a one-deep output register and in-flight credit tracking.
module vx_fpu_req_sched
   import vx_fpu_req_sched_pkg::*;
#(
   parameter int NUM_REQS   = DEF_NUM_REQS,
   parameter int DATAW      = DEF_DATAW,
   parameter int QUEUE_SIZE = DEF_QUEUE_SIZE
) (
   input logic               clk,
   input logic               reset,
   vx_fpu_req_sched_if.slave io_bus
);

   localparam int IDXW = idx_width(NUM_REQS);
   localparam int CNTW = cnt_width(QUEUE_SIZE);

   logic                          w_arb_valid;
   logic [IDXW-1:0]               w_winner;
   logic                          w_space;
   logic                          w_out_free;
   logic                          w_fire;
   logic                          w_fire_eop;
   logic                          w_advance;
   logic [NUM_REQS-1:0]           w_ready;
   logic [NUM_REQS-1:0]           w_idle;
   logic [NUM_REQS-1:0]           w_inc;
   logic [NUM_REQS-1:0]           w_dec;
   logic                          w_rsp_zero;

   lock_state_e                   r_lock;
   lock_state_e                   w_lock_next;
   logic [IDXW-1:0]               r_owner;
   logic [IDXW-1:0]               w_owner_next;

   logic                          r_out_valid;
   logic [DATAW-1:0]              r_out_data;
   logic [IDXW-1:0]               r_out_idx;
   logic                          r_out_eop;

   logic [CNTW-1:0]               r_inflight;
   logic [CNTW-1:0]               w_inflight_next;
   logic [NUM_REQS-1:0][CNTW-1:0] r_cnt;
   logic [NUM_REQS-1:0][CNTW-1:0] w_cnt_next;

   vx_fpu_req_sched_arb #(
      .NUM_REQS (NUM_REQS),
      .IDXW     (IDXW)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (io_bus.req_valid),
      .i_lock    (r_lock == LOCK_LOCKED),
      .i_owner   (r_owner),
      .i_advance (w_advance),
      .o_valid   (w_arb_valid),
      .o_winner  (w_winner)
   );

   // Fire decision; credit uses only the registered count so a same-cycle retire cannot unblock
   always_comb begin
      w_space    = (r_inflight < CNTW'(QUEUE_SIZE));
      w_out_free = !r_out_valid || io_bus.out_ready;
      w_fire     = !reset && w_arb_valid && w_out_free && w_space;
      w_fire_eop = io_bus.req_eop[w_winner];
      w_advance  = w_fire && w_fire_eop;
      w_ready    = {NUM_REQS{1'b0}};
      if (w_fire) begin
         w_ready[w_winner] = 1'b1;
      end else begin
         w_ready = {NUM_REQS{1'b0}};
      end
   end

   // Lock next-state: a non-final packet claims the port until that requester's eop
   always_comb begin
      w_lock_next  = r_lock;
      w_owner_next = r_owner;
      case (r_lock)
         LOCK_UNLOCKED: begin
            if (w_fire && !w_fire_eop) begin
               w_lock_next  = LOCK_LOCKED;
               w_owner_next = w_winner;
            end else begin
               w_lock_next  = LOCK_UNLOCKED;
            end
         end
         LOCK_LOCKED: begin
            if (w_fire && w_fire_eop) begin
               w_lock_next = LOCK_UNLOCKED;
            end else begin
               w_lock_next = LOCK_LOCKED;
            end
         end
         default: begin
            w_lock_next = LOCK_UNLOCKED;
         end
      endcase
   end

   // Lock state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock  <= LOCK_UNLOCKED;
         r_owner <= {IDXW{1'b0}};
      end else begin
         r_lock  <= w_lock_next;
         r_owner <= w_owner_next;
      end
   end

   // Output register: loads on fire, holds until the FPU accepts it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= {DATAW{1'b0}};
         r_out_idx   <= {IDXW{1'b0}};
         r_out_eop   <= 1'b0;
      end else if (w_fire) begin
         r_out_valid <= 1'b1;
         r_out_data  <= io_bus.req_data[w_winner];
         r_out_idx   <= w_winner;
         r_out_eop   <= w_fire_eop;
      end else if (io_bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Credit counters: issue adds, retire subtracts, both together cancel, floor at zero
   always_comb begin
      w_inflight_next = r_inflight;
      if (w_fire && !io_bus.rsp_done) begin
         w_inflight_next = r_inflight + 1'b1;
      end else if (!w_fire && io_bus.rsp_done && (r_inflight != {CNTW{1'b0}})) begin
         w_inflight_next = r_inflight - 1'b1;
      end else begin
         w_inflight_next = r_inflight;
      end

      w_inc      = {NUM_REQS{1'b0}};
      w_dec      = {NUM_REQS{1'b0}};
      w_cnt_next = r_cnt;
      for (int i = 0; i < NUM_REQS; i++) begin
         w_inc[i] = w_fire && (w_winner == IDXW'(i));
         w_dec[i] = io_bus.rsp_done && (io_bus.rsp_idx == IDXW'(i));
         if (w_inc[i] && !w_dec[i]) begin
            w_cnt_next[i] = r_cnt[i] + 1'b1;
         end else if (!w_inc[i] && w_dec[i] && (r_cnt[i] != {CNTW{1'b0}})) begin
            w_cnt_next[i] = r_cnt[i] - 1'b1;
         end else begin
            w_cnt_next[i] = r_cnt[i];
         end
      end
   end

   // Credit counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight <= {CNTW{1'b0}};
         r_cnt      <= {(NUM_REQS * CNTW){1'b0}};
      end else begin
         r_inflight <= w_inflight_next;
         r_cnt      <= w_cnt_next;
      end
   end

   // Idle flags and retire-underflow detect from registered counts
   always_comb begin
      w_idle = {NUM_REQS{1'b0}};
      for (int i = 0; i < NUM_REQS; i++) begin
         w_idle[i] = (r_cnt[i] == {CNTW{1'b0}});
      end
      w_rsp_zero = (r_cnt[io_bus.rsp_idx] == {CNTW{1'b0}});
   end

   vx_fpu_req_sched_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .i_rsp_done (io_bus.rsp_done),
      .i_rsp_zero (w_rsp_zero),
      .i_fire     (w_fire),
      .i_sop      (io_bus.req_sop[w_winner]),
      .i_unlocked (r_lock == LOCK_UNLOCKED)
   );

   assign io_bus.req_ready = w_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_data  = r_out_data;
   assign io_bus.out_idx   = r_out_idx;
   assign io_bus.out_eop   = r_out_eop;
   assign io_bus.inflight  = r_inflight;
   assign io_bus.req_idle  = w_idle;

endmodule

// File: tb/tb_vx_fpu_req_sched.sv
// Table-driven bench for vx_fpu_req_sched with an issue-order scoreboard.
module tb_vx_fpu_req_sched;
   import vx_fpu_req_sched_pkg::*;

   localparam int NR = 4;
   localparam int DW = 128;
   localparam int QS = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   vx_fpu_req_sched_if #(.NUM_REQS(NR), .DATAW(DW), .QUEUE_SIZE(QS)) bus ();

   vx_fpu_req_sched #(.NUM_REQS(NR), .DATAW(DW), .QUEUE_SIZE(QS)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus.slave)
   );

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic [3:0] s;
      logic [3:0] e;
      logic       ordy;
      logic       done;
      logic [1:0] didx;
      logic [3:0] er;
      logic [3:0] ei;
      logic [3:0] eid;
   } vec_t;

   typedef struct {
      logic [1:0]    idx;
      logic [DW-1:0] data;
      logic          eop;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic logic [DW-1:0] mk_data(input int r, input int t);
      logic [7:0] rb;
      logic [7:0] tb;
      rb = 8'(r);
      tb = 8'(t);
      return {4{rb, tb, 16'hC0DE}};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] s,
                      input logic [3:0] e, input logic ordy, input logic done,
                      input logic [1:0] didx, input logic [3:0] er, input logic [3:0] ei,
                      input logic [3:0] eid);
      vec_t x;
      x.rst = rst; x.v = v; x.s = s; x.e = e; x.ordy = ordy; x.done = done;
      x.didx = didx; x.er = er; x.ei = ei; x.eid = eid;
      vq.push_back(x);
   endtask

   task automatic drive(input vec_t x, input int t);
      reset          = x.rst;
      bus.req_valid  = x.v;
      bus.req_sop    = x.s;
      bus.req_eop    = x.e;
      bus.out_ready  = x.ordy;
      bus.rsp_done   = x.done;
      bus.rsp_idx    = x.didx;
      for (int r = 0; r < NR; r++) begin
         bus.req_data[r] = mk_data(r, t);
      end
   endtask

   task automatic reset_checks(input int row);
      chk($sformatf("r%0d rst out_valid", row), DW'(bus.out_valid), DW'(1'b0));
      chk($sformatf("r%0d rst out_idx", row), DW'(bus.out_idx), DW'(2'd0));
      chk($sformatf("r%0d rst out_data", row), bus.out_data, {DW{1'b0}});
      chk($sformatf("r%0d rst req_ready", row), DW'(bus.req_ready), DW'(4'b0000));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t x;
      // rst  valid    sop      eop      ordy  done  didx   ready    infl   idle
      add(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd0, 4'b1111);
      // all requesters, single packets: 0,1,2,3,0
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd1, 4'b1110);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd2, 4'b1100);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd3, 4'b1000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 4'd4, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd5, 4'b0000);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'd4, 4'b0000);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'd3, 4'b0001);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd2, 4'b0011);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'd1, 4'b0111);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 4'b0000, 4'd0, 4'b1111);
      // req1 four-packet stream with req0/req2 contending; req1 drops valid mid-stream
      add(1'b0, 4'h7, 4'h7, 4'h5, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd1, 4'b1101);
      add(1'b0, 4'h7, 4'h5, 4'h5, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd2, 4'b1101);
      add(1'b0, 4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd2, 4'b1101);
      add(1'b0, 4'h7, 4'h5, 4'h5, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd3, 4'b1101);
      add(1'b0, 4'h7, 4'h5, 4'h7, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd4, 4'b1101);
      add(1'b0, 4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd5, 4'b1001);
      add(1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd6, 4'b1000);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd5, 4'b1000);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd4, 4'b1000);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd3, 4'b1000);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd2, 4'b1010);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'd1, 4'b1011);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'd0, 4'b1111);
      // req2 issue and retire in the same cycle at inflight 3
      add(1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd1, 4'b1011);
      add(1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd2, 4'b1011);
      add(1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd3, 4'b1011);
      add(1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 1'b1, 2'd2, 4'b0100, 4'd3, 4'b1011);
      for (int k = 0; k < 2; k++) begin
         add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'(2 - k), 4'b1011);
      end
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'd0, 4'b1111);
      // FPU back-pressure for three cycles
      add(1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd1, 4'b1110);
      for (int k = 0; k < 3; k++) begin
         add(1'b0, 4'h3, 4'h3, 4'h3, 1'b0, 1'b0, 2'd0, 4'b0000, 4'd1, 4'b1110);
      end
      add(1'b0, 4'h3, 4'h3, 4'h3, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd2, 4'b1100);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'd1, 4'b1101);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd0, 4'b1111);
      // fill the credit pool, then one retire frees exactly one issue a cycle later
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd1, 4'b1011);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 4'd2, 4'b0011);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd3, 4'b0010);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd4, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd5, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 4'd6, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd7, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd8, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd8, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd8, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 4'b0000, 4'd7, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd8, 4'b0000);
      add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd8, 4'b0000);
      // reset while locked on req1 with a held output
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'd7, 4'b0000);
      add(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd8, 4'b0000);
      add(1'b1, 4'h7, 4'h7, 4'h7, 1'b0, 1'b0, 2'd0, 4'b0000, 4'd0, 4'b1111);
      add(1'b0, 4'h7, 4'h7, 4'h7, 1'b1, 1'b0, 2'd0, 4'b0001, 4'd1, 4'b1110);
      add(1'b0, 4'h7, 4'h7, 4'h7, 1'b1, 1'b0, 2'd0, 4'b0010, 4'd2, 4'b1100);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'd1, 4'b1101);
      add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 4'd0, 4'b1111);

      drive(vq[0], 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < vq.size(); i++) begin
         x = vq[i];
         drive(x, i);
         @(negedge clk);
         chk($sformatf("r%0d req_ready", i), DW'(bus.req_ready), DW'(x.er));
         chk($sformatf("r%0d out_valid", i), DW'(bus.out_valid), DW'(sb.size() != 0));
         if (sb.size() != 0) begin
            chk($sformatf("r%0d out_idx", i), DW'(bus.out_idx), DW'(sb[0].idx));
            chk($sformatf("r%0d out_data", i), bus.out_data, sb[0].data);
            chk($sformatf("r%0d out_eop", i), DW'(bus.out_eop), DW'(sb[0].eop));
            if (x.ordy) begin
               void'(sb.pop_front());
            end
         end
         if (x.rst) begin
            sb.delete();
         end else begin
            for (int r = 0; r < NR; r++) begin
               if (x.er[r]) begin
                  sb.push_back('{idx: 2'(r), data: mk_data(r, i), eop: x.e[r]});
               end
            end
         end
         @(posedge clk);
         #1;
         chk($sformatf("r%0d inflight", i), DW'(bus.inflight), DW'(x.ei));
         chk($sformatf("r%0d req_idle", i), DW'(bus.req_idle), DW'(x.eid));
         if (x.rst) begin
            reset_checks(i);
         end
      end
      chk("scoreboard empty", DW'(sb.size()), DW'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/vx_fpu_req_sched.md
VX_FPU_REQ_SCHED -- requirements
Module: VX_fpu_req_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of issue slots sharing one FPU block.
REQ-002 SHALL have parameter DATAW, default 128: opaque request payload width.
REQ-003 SHALL have parameter QUEUE_SIZE, default 8: max in-flight FPU ops, equal to FPUQ_SIZE.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NUM_REQS  per-requester request valid.
REQ-008 req_data  in  NUM_REQS x DATAW  per-requester payload.
REQ-009 req_sop / req_eop  in  NUM_REQS each  first/last packet of a multi-packet (PID) instruction.
REQ-010 req_ready  out  NUM_REQS  per-requester accept.
REQ-011 out_valid  out  1 / out_data  out  DATAW / out_idx  out  CLOG2(NUM_REQS) / out_eop  out  1  request to the FPU.
REQ-012 out_ready  in  1  FPU accept.
REQ-013 rsp_done  in  1 / rsp_idx  in  CLOG2(NUM_REQS)  one FPU response retired for requester rsp_idx.
REQ-014 inflight  out  CLOG2(QUEUE_SIZE+1)  total in-flight count; req_idle  out  NUM_REQS  requester has zero in-flight ops.

Function
REQ-015 SHALL select one winner per cycle among valid requesters by round-robin from priority pointer rr_ptr.
REQ-016 Request fires when req_valid[i] && req_ready[i]; at most one req_ready bit high per cycle.
REQ-017 req_ready[i] SHALL be high only when i is the winner, output register is free or draining (!out_valid || out_ready), and inflight < QUEUE_SIZE.
REQ-018 Output register SHALL load on request fire: out_data, out_idx = winner, out_eop; latency exactly 1 cycle from fire to out_valid.
REQ-019 out_valid SHALL hold with stable out_data/out_idx until out_ready; back-to-back fires allowed (full throughput).
REQ-020 Lock FSM states UNLOCKED, LOCKED(owner): fire with !eop -> LOCKED(winner); fire with eop in LOCKED -> UNLOCKED.
REQ-021 In LOCKED only owner SHALL be eligible; other requesters see req_ready low regardless of validity.
REQ-022 rr_ptr SHALL advance to (winner+1) mod NUM_REQS only on a fire with eop; unchanged otherwise.
REQ-023 inflight SHALL increment on request fire, decrement on rsp_done; simultaneous -> unchanged.
REQ-024 Per-requester counters SHALL track in-flight ops likewise (fire on winner, rsp_done on rsp_idx, same index simultaneous -> unchanged); req_idle[i] = counter[i]==0.
REQ-025 At inflight == QUEUE_SIZE all req_ready SHALL be low; a same-cycle rsp_done SHALL NOT enable a fire that cycle (registered credit).
REQ-026 rsp_done with zero count is illegal: counters saturate at 0 and a simulation assertion fires.
REQ-027 req_valid deasserting while LOCKED SHALL keep the lock (no timeout).

Reset
REQ-028 On reset: out_valid=0, out_idx=0, out_data=0, rr_ptr=0, lock=UNLOCKED, inflight=0, all per-requester counters 0, req_idle all 1, req_ready all 0.
REQ-029 Reset mid-sequence SHALL drop the locked packet stream and any held output without completion.

Structure
REQ-030 Lock state encoding and counter width constants SHALL live in VX_fpu_pkg.
REQ-031 Round-robin selection SHALL be a sub-module VX_rr_arbiter instance (with lock/hold input); counters and output register stay in VX_fpu_req_sched.

Verification
REQ-032 Requesters 0..3 all valid, sop=eop=1, out_ready=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 Req1 sends 4 packets (sop on first, eop on fourth) while req0,req2 valid -> out_idx 1,1,1,1 then 2,3?no-valid skip ->2,0.
REQ-034 QUEUE_SIZE=8, no rsp_done, 10 single-packet requests -> 8 accepted, inflight=8, req_ready stays 0; one rsp_done -> next cycle one fire.
REQ-035 out_ready low 3 cycles with out_valid=1 -> out_data/out_idx stable, no further fires, inflight unchanged.
REQ-036 Fire and rsp_done same cycle on req2 at inflight=3 -> inflight stays 3, req_idle[2] unchanged.
REQ-037 Reset asserted while LOCKED(1) with out_valid=1 -> next cycle out_valid=0, inflight=0, arbitration restarts at requester 0.
